namco_tile_linebuf: RTL and testbench

//  Parametrised tile-layer scanline renderer for the Namco video cores: BG/FG planes with scroll and mirrored readout.

---
 rtl/namco_tile_linebuf.sv | 146 ++++++++++++++
 tb/tb_namco_tile_linebuf.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/namco_tile_linebuf.sv
// namco_tile_linebuf: ping-pong tile scanline renderer; renders line N+1 from VRAM/char ROM while line N is read out
// Ports: i_clk48m/i_reset clock and sync reset; i_pclk_en/i_posh/i_posv video timing; i_hscroll/i_vscroll/i_flipx
//   scroll and mirror; o_vr_req/o_vr_ad/i_vr_dt/i_vr_ack VRAM handshake; o_cr_ad/i_cr_dt char ROM (1-cycle latency);
//   o_pix/o_pix_opq {attr,pixel} and opacity to the mixer; o_overrun sticky late-render flag.
module namco_tile_linebuf #(
  parameter int HPIX   = 288,
  parameter int BPP    = 2,
  parameter int CODEW  = 8,
  parameter int CRAW   = 12,
  parameter int LSTART = 288,
  parameter int OSTART = 0
) (
  input  logic            i_clk48m,
  input  logic            i_reset,
  input  logic            i_pclk_en,
  input  logic [8:0]      i_posh,
  input  logic [8:0]      i_posv,
  input  logic [8:0]      i_hscroll,
  input  logic [7:0]      i_vscroll,
  input  logic            i_flipx,
  output logic            o_vr_req,
  output logic [9:0]      o_vr_ad,
  input  logic [CODEW-1:0] i_vr_dt,
  input  logic            i_vr_ack,
  output logic [CRAW-1:0] o_cr_ad,
  input  logic [7:0]      i_cr_dt,
  output logic [3+BPP:0]  o_pix,
  output logic            o_pix_opq,
  output logic            o_overrun
);
  localparam int NT = HPIX / 8;
  typedef enum logic [2:0] {IDLE, FETCH, ROM0, ROM1, WRITE} state_t;
  state_t            r_st;
  logic              r_bank, r_vr_req, r_overrun, r_pix_opq;
  logic [9:0]        r_vr_ad;
  logic [CRAW-1:0]   r_cr_ad;
  logic [3+BPP:0]    r_pix;
  logic [7:0]        r_hs, r_y, r_b0, r_b1;
  logic [6:0]        r_t;
  logic [2:0]        r_p;
  logic [CODEW-1:0]  r_code;
  logic [3+BPP:0]    r_buf [1024];
  logic              w_ls, w_wr_in, w_rin, w_unused;
  logic [7:0]        w_y0, w_byte;
  logic [6:0]        w_tn;
  logic [4:0]        w_col;
  logic [2:0]        w_hi, w_lo;
  logic [1:0]        w_v2;
  logic [3+BPP:0]    w_pix, w_rd;
  logic [10:0]       w_x;
  logic [9:0]        w_rx;
  logic [8:0]        w_ra;
  logic [CODEW+3:0]  w_cra1, w_cra0;
  assign w_unused = &{1'b0, i_posv[8], i_hscroll[8]};
  assign w_ls    = i_pclk_en && i_posh == 9'(LSTART);
  assign w_y0    = i_posv[7:0] + 8'd1 + i_vscroll;
  assign w_tn    = r_t + 7'd1;
  assign w_col   = r_hs[7:3] + w_tn[4:0];
  // BPP=1 takes pixel 0 straight off the ROM bus; later pixels use the latched byte
  assign w_byte  = (BPP == 1) ? ((r_p == 3'd0) ? i_cr_dt : r_b0) : (r_p[2] ? r_b0 : r_b1);
  assign w_hi    = 3'd7 - {1'b0, r_p[1:0]};
  assign w_lo    = 3'd3 - {1'b0, r_p[1:0]};
  assign w_v2    = (BPP == 1) ? {1'b0, w_byte[r_p]} : {w_byte[w_hi], w_byte[w_lo]};
  assign w_pix   = {r_code[CODEW-1 -: 4], w_v2[BPP-1:0]};
  assign w_x     = {1'b0, r_t, r_p} - {8'b0, r_hs[2:0]};
  assign w_wr_in = !w_x[10] && w_x < 11'(HPIX);
  assign w_rx    = {1'b0, i_posh} - 10'(OSTART);
  assign w_rin   = !w_rx[9] && w_rx < 10'(HPIX);
  assign w_ra    = i_flipx ? 9'(HPIX - 1) - w_rx[8:0] : w_rx[8:0];
  assign w_rd    = r_buf[{~r_bank, w_ra}];
  assign w_cra1  = (BPP == 1) ? {1'b0, i_vr_dt, r_y[2:0]} : {i_vr_dt, 1'b1, r_y[2:0]};
  assign w_cra0  = {r_code, 1'b0, r_y[2:0]};
  always_ff @(posedge i_clk48m)
    if (!i_reset && r_st == WRITE && w_wr_in) r_buf[{r_bank, w_x[8:0]}] <= w_pix;
  always_ff @(posedge i_clk48m) begin
    if (i_reset) begin
      r_st      <= IDLE;
      r_bank    <= 1'b0;
      r_vr_req  <= 1'b0;
      r_vr_ad   <= '0;
      r_cr_ad   <= '0;
      r_pix     <= '0;
      r_pix_opq <= 1'b0;
      r_overrun <= 1'b0;
      r_t       <= '0;
      r_p       <= '0;
    end else begin
      if (i_pclk_en) begin
        r_pix     <= w_rin ? w_rd : '0;
        r_pix_opq <= w_rin && |w_rd[BPP-1:0];
      end
      if (w_ls) begin
        r_bank   <= ~r_bank;
        r_hs     <= i_hscroll[7:0];
        r_y      <= w_y0;
        r_t      <= '0;
        r_p      <= '0;
        r_st     <= FETCH;
        // an aborted request is dropped for one cycle before the new line re-requests
        r_vr_req <= r_st == IDLE;
        r_vr_ad  <= {w_y0[7:3], i_hscroll[7:3]};
        if (r_st != IDLE) r_overrun <= 1'b1;
      end else begin
        case (r_st)
          FETCH: begin
            if (!r_vr_req) r_vr_req <= 1'b1;
            else if (i_vr_ack) begin
              r_vr_req <= 1'b0;
              r_code   <= i_vr_dt;
              r_cr_ad  <= CRAW'(w_cra1);
              r_st     <= ROM0;
            end
          end
          ROM0: begin
            if (BPP != 1) r_cr_ad <= CRAW'(w_cra0);
            r_st <= (BPP == 1) ? WRITE : ROM1;
          end
          ROM1: begin
            r_b1 <= i_cr_dt;
            r_st <= WRITE;
          end
          WRITE: begin
            if (r_p == 3'd0) r_b0 <= i_cr_dt;
            r_p <= r_p + 3'd1;
            if (r_p == 3'd7) begin
              if (r_t == 7'(NT)) r_st <= IDLE;
              else begin
                r_t      <= w_tn;
                r_st     <= FETCH;
                r_vr_req <= 1'b1;
                r_vr_ad  <= {r_y[7:3], w_col};
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
  assign o_vr_req  = r_vr_req;
  assign o_vr_ad   = r_vr_ad;
  assign o_cr_ad   = r_cr_ad;
  assign o_pix     = r_pix;
  assign o_pix_opq = r_pix_opq;
  assign o_overrun = r_overrun;
endmodule

// File: tb/tb_namco_tile_linebuf.sv
// tb_namco_tile_linebuf: random scroll/flip/VRAM/ROM lines checked against a per-pixel reference renderer
module tb_namco_tile_linebuf;
  localparam int HPIX = 288, LSTART = 288, NL = 10;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       i_reset = 1'b1, i_pclk_en = 1'b0, i_flipx = 1'b0, i_vr_ack, o_vr_req, o_pix_opq, o_overrun;
  logic [8:0] i_posh = '0, i_posv = '0, i_hscroll = '0;
  logic [7:0] i_vscroll = '0, i_vr_dt, i_cr_dt;
  logic [9:0] o_vr_ad;
  logic [11:0] o_cr_ad;
  logic [5:0] o_pix;
  namco_tile_linebuf dut (
    .i_clk48m(clk), .i_reset(i_reset), .i_pclk_en(i_pclk_en), .i_posh(i_posh), .i_posv(i_posv),
    .i_hscroll(i_hscroll), .i_vscroll(i_vscroll), .i_flipx(i_flipx), .o_vr_req(o_vr_req), .o_vr_ad(o_vr_ad),
    .i_vr_dt(i_vr_dt), .i_vr_ack(i_vr_ack), .o_cr_ad(o_cr_ad), .i_cr_dt(i_cr_dt), .o_pix(o_pix),
    .o_pix_opq(o_pix_opq), .o_overrun(o_overrun)
  );
  typedef struct { bit chk; logic [6:0] exp; int line; int posh; } exp_t;
  exp_t q[$];
  logic [7:0] vram [1024];
  logic [7:0] rom [4096];
  logic [5:0] wr_img [HPIX];
  logic [5:0] disp_img [HPIX];
  bit   wr_ok = 0, disp_ok = 0, busy_m = 0, ovr_m = 0;
  int   n_chk = 0, n_pass = 0, delay = 0, cur_line = -1, cur_posh = 0;
  logic [8:0] hs_c [NL];
  logic [7:0] vs_c [NL];
  bit   fl_c [NL];
  int   dl_c [NL];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (line %0d posh %0d)", name, act, exp, cur_line, cur_posh);
  endtask
  // reference: every output x is traced back to its tile, column, ROM byte and bit pair
  task automatic do_render(input logic [8:0] hs, input logic [7:0] vs, input int pv);
    logic [7:0] y, code, b;
    int sx, t, p, col;
    y = 8'(pv) + 8'd1 + vs;
    for (int x = 0; x < HPIX; x++) begin
      sx = x + int'(hs[2:0]);
      t = sx / 8;
      p = sx % 8;
      col = (int'(hs) / 8 + t) % 32;
      code = vram[int'(y[7:3]) * 32 + col];
      b = rom[int'(code) * 16 + (p < 4 ? 8 : 0) + int'(y[2:0])];
      wr_img[x] = {code[7:4], b[7 - p % 4], b[3 - p % 4]};
    end
  endtask
  // VRAM: ack after 'delay' cycles of continuous request; stray acks while idle
  initial begin
    int wcnt = 0;
    i_vr_ack = 1'b0;
    i_vr_dt = '0;
    forever begin
      @(negedge clk);
      if (o_vr_req) begin
        if (wcnt >= delay) begin
          i_vr_ack = 1'b1;
          i_vr_dt = vram[o_vr_ad];
        end else begin
          i_vr_ack = 1'b0;
          wcnt++;
        end
      end else begin
        wcnt = 0;
        i_vr_ack = ($urandom_range(0, 7) == 0);
        i_vr_dt = 8'($urandom);
      end
    end
  end
  // char ROM: data for the address presented in one cycle appears in the next
  initial begin
    logic [7:0] pend = '0;
    i_cr_dt = '0;
    forever begin
      @(negedge clk);
      i_cr_dt = pend;
      pend = rom[o_cr_ad];
    end
  end
  // monitor: one cycle after each pixel strobe the registered output is compared
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (i_pclk_en) begin
        @(negedge clk);
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL pix_queue: output with no expectation at line %0d posh %0d", cur_line, cur_posh);
        end else begin
          e = q.pop_front();
          if (e.chk) check($sformatf("pix_l%0d_x%0d", e.line, e.posh), {o_pix, o_pix_opq}, e.exp);
        end
      end
    end
  end
  // mid-line reset while a VRAM request is pending
  initial begin
    bit found = 0;
    wait (cur_line == 6 && cur_posh >= 300);
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      found = o_vr_req;
    end
    check("req_before_reset", 32'(found), 1);
    check("overrun_before_reset", o_overrun, 1);
    i_reset = 1'b1;
    @(negedge clk);
    check("req_after_reset", o_vr_req, 0);
    check("overrun_after_reset", o_overrun, 0);
    i_reset = 1'b0;
    ovr_m = 0;
    busy_m = 0;
    wr_ok = 0;
    disp_ok = 0;
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    exp_t e;
    logic [5:0] px;
    bit ls, abort;
    for (int i = 0; i < 1024; i++) vram[i] = 8'($urandom);
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    for (int v = 0; v < NL; v++) begin
      hs_c[v] = 9'($urandom);
      vs_c[v] = 8'($urandom);
      fl_c[v] = 1'($urandom);
      dl_c[v] = $urandom_range(0, 3);
    end
    hs_c[0] = 0; vs_c[0] = 0; dl_c[0] = 0;
    hs_c[1] = 3; fl_c[2] = 0; fl_c[3] = 1;
    dl_c[4] = 300;
    hs_c[7] = 5; dl_c[7] = 0; fl_c[9] = 1;
    repeat (3) @(negedge clk);
    check("rst_vr_req", o_vr_req, 0);
    check("rst_vr_ad", o_vr_ad, 0);
    check("rst_cr_ad", o_cr_ad, 0);
    check("rst_pix", o_pix, 0);
    check("rst_pix_opq", o_pix_opq, 0);
    check("rst_overrun", o_overrun, 0);
    i_reset = 1'b0;
    for (int v = 0; v < NL; v++) begin
      for (int h = 0; h < 512; h++) begin
        @(negedge clk);
        ls = 0;
        abort = 0;
        if (h == 0) i_flipx = fl_c[v];
        if (h == LSTART) begin
          i_hscroll = hs_c[v];
          i_vscroll = vs_c[v];
          ls = 1;
          abort = busy_m;
          if (busy_m) ovr_m = 1;
          disp_img = wr_img;
          disp_ok = wr_ok;
          do_render(hs_c[v], vs_c[v], v);
          wr_ok = dl_c[v] < 100;
          busy_m = dl_c[v] >= 100;
          delay = dl_c[v];
        end
        i_pclk_en = 1'b1;
        i_posh = 9'(h);
        i_posv = 9'(v);
        cur_line = v;
        cur_posh = h;
        e.line = v;
        e.posh = h;
        if (h < HPIX) begin
          px = i_flipx ? disp_img[HPIX - 1 - h] : disp_img[h];
          e.chk = disp_ok;
          e.exp = {px, px[1:0] != 2'd0};
        end else begin
          e.chk = 1;
          e.exp = '0;
        end
        q.push_back(e);
        @(negedge clk);
        i_pclk_en = 1'b0;
        if (ls) check($sformatf("overrun_l%0d", v), o_overrun, 32'(ovr_m));
        if (abort) check("req_drop_on_abort", o_vr_req, 0);
        repeat (6) @(negedge clk);
      end
    end
    repeat (4) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
